inst_decode: RTL and testbench
==============================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 Parameter CNT_W, default 16, width of the decoded-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  instruction word present on in_inst.
REQ-005 in_inst  input  9  instruction word: [8:6] opcode, [5:4] funct, [3:0] operand.
REQ-006 in_ready  output  1  block accepts in_inst this cycle.
REQ-007 flush  input  1  discard the held output entry; block input this cycle.
REQ-008 out_valid  output  1  decoded entry present on out_* fields.
REQ-009 out_ready  input  1  consumer takes the decoded entry.
REQ-010 out_type  output  2  TopLevel_def InstType: I=0, M=1, B=2, R=3.
REQ-011 out_opcode / out_funct  output  3 / 2  registered copies of in_inst[8:6] / [5:4].
REQ-012 out_ra / out_rb  output  2 / 2  register fields in_inst[3:2] / in_inst[1:0].
REQ-013 out_imm  output  8  immediate derived from in_inst[3:0].
REQ-014 out_is_load / out_is_store / out_is_branch / out_reg_write / out_is_halt  output  1 each  control flags.
REQ-015 halted  output  1  block is in HALTED state.
REQ-016 dec_count  output  CNT_W  count of entries consumed at the output.

Function
REQ-017 Opcode map: R_ADD=0, R_SHF=1, R_NEG=2, I_LW=3, I_SW=4, I_SET=5, B_BEQ=6, M_MOV=7. This map matches the TopLevel_def package.
REQ-018 Type map: opcodes 0,1,2 -> R. Opcodes 3,4,5 -> I. Opcode 6 -> B. Opcode 7 -> M.
REQ-019 out_imm: B type sign-extends in_inst[3:0]. All other types zero-extend in_inst[3:0].
REQ-020 Flags:
  - out_is_load = I_LW.
  - out_is_store = I_SW.
  - out_is_branch = B_BEQ, any funct (BEQ/BNE/BLTS/BLT).
  - out_is_halt = R_NEG with funct 3 (FUN_HALT).
  - out_reg_write = 1 for R_ADD, R_SHF, R_NEG with funct 0..2, I_LW, I_SET, M_MOV; 0 for all other opcode/funct combinations.
REQ-021 One-entry output register. Latency: an input accepted at edge N is valid on out_* after edge N.
REQ-022 in_ready = (!out_valid || out_ready) && !halted && !flush. in_ready is combinational from these terms only.
REQ-023 Accept = in_valid && in_ready. Accept loads all out_* fields and sets out_valid.
REQ-024 Output handshake = out_valid && out_ready with no accept in the same cycle: clears out_valid.
REQ-025 Output handshake and accept in the same cycle: new entry replaces the old one; out_valid stays 1 (full throughput).
REQ-026 While out_valid=1 and out_ready=0, all out_* fields stay stable.
REQ-027 flush=1: out_valid=0 next cycle regardless of out_ready. No accept occurs in that cycle. dec_count does not increment for an entry that is flushed without an output handshake.
REQ-028 State machine RUN -> HALTED: taken at the edge where an instruction with out_is_halt is accepted.
REQ-029 The HALT instruction itself is presented on the output normally. halted=1 from the following cycle.
REQ-030 HALTED is left only by reset. flush does not change state.
REQ-031 dec_count increments by 1 on each output handshake. It saturates at 2^CNT_W-1 and does not wrap.
REQ-032 Output handshake and flush in the same cycle: the handshake counts; out_valid goes to 0.

Reset
REQ-033 While rst_n=0:
  - out_valid=0, halted=0 (state RUN), dec_count=0.
  - All out_* data fields = 0.
  - in_ready=0.
REQ-034 Reset asserted mid-transaction discards any held entry immediately. No output handshake is reported for that entry.
REQ-035 First accept is possible in the first cycle with rst_n=1.

Verification
REQ-036 in_inst=9'b011_00_0101 (LW), out_ready=1 -> next cycle:
  - out_type=I, out_is_load=1, out_reg_write=1, out_imm=8'h05.
  - dec_count=1 after the handshake.
REQ-037 in_inst=9'b110_01_1110 (BNE, imm -2) -> out_type=B, out_funct=1, out_is_branch=1, out_imm=8'hFE, out_reg_write=0.
REQ-038 Back-to-back stream of 4 valid instructions with out_ready=1 -> 4 outputs on consecutive cycles, dec_count=4. Then hold out_ready=0 for 3 cycles -> out_* stable, in_ready=0.
REQ-039 Accept 9'b010_11_0000 (HALT) -> out_is_halt=1 next cycle; halted=1; in_ready=0 thereafter with in_valid=1. Reset -> halted=0.
REQ-040 Held entry with out_ready=0, then flush=1 -> out_valid=0 next cycle, dec_count unchanged, in_valid ignored during the flush cycle.
REQ-041 CNT_W=2, 5 consumed entries -> dec_count=3 (saturated).

Source files
------------

// File: rtl/inst_decode.sv
// inst_decode: single-stage instruction decoder with a one-entry output
// register, valid/ready handshakes on both sides, flush, a sticky HALTED
// state and a saturating count of consumed entries.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_inst  instruction word {opcode[8:6], funct[5:4], operand[3:0]}
//   in_ready          block accepts in_inst this cycle (combinational)
//   flush             drop the held entry and block input this cycle
//   out_valid/ready   output handshake for the decoded entry
//   out_type          instruction type (I=0, M=1, B=2, R=3)
//   out_opcode/funct  copies of the opcode and funct fields
//   out_ra/out_rb     register fields in_inst[3:2] / in_inst[1:0]
//   out_imm           8-bit immediate (sign-extended for B type)
//   out_is_*          control flags, out_reg_write register write enable
//   halted            a HALT has been accepted; left only by reset
//   dec_count         saturating count of output handshakes
module inst_decode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [8:0]       in_inst,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_type,
  output logic [2:0]       out_opcode,
  output logic [1:0]       out_funct,
  output logic [1:0]       out_ra,
  output logic [1:0]       out_rb,
  output logic [7:0]       out_imm,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_branch,
  output logic             out_reg_write,
  output logic             out_is_halt,
  output logic             halted,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [2:0] {
    R_ADD = 3'd0,
    R_SHF = 3'd1,
    R_NEG = 3'd2,
    I_LW  = 3'd3,
    I_SW  = 3'd4,
    I_SET = 3'd5,
    B_BEQ = 3'd6,
    M_MOV = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    T_I = 2'd0,
    T_M = 2'd1,
    T_B = 2'd2,
    T_R = 2'd3
  } inst_type_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  localparam logic [1:0] FUN_HALT = 2'd3;

  state_t           r_state;
  logic             r_valid;
  inst_type_t       r_type;
  logic [2:0]       r_opcode;
  logic [1:0]       r_funct;
  logic [1:0]       r_ra;
  logic [1:0]       r_rb;
  logic [7:0]       r_imm;
  logic             r_is_load;
  logic             r_is_store;
  logic             r_is_branch;
  logic             r_reg_write;
  logic             r_is_halt;
  logic [CNT_W-1:0] r_count;

  opcode_t          w_op;
  inst_type_t       w_type;
  logic [7:0]       w_imm;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_branch;
  logic             w_reg_write;
  logic             w_is_halt;
  logic             w_halted;
  logic             w_accept;
  logic             w_handshake;

  // Decode of the incoming word, used only when the word is accepted.
  always_comb begin
    w_op        = opcode_t'(in_inst[8:6]);
    w_type      = T_R;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_reg_write = 1'b0;
    w_is_halt   = 1'b0;
    case (w_op)
      R_ADD, R_SHF: begin
        w_type      = T_R;
        w_reg_write = 1'b1;
      end
      R_NEG: begin
        w_type      = T_R;
        w_is_halt   = (in_inst[5:4] == FUN_HALT);
        w_reg_write = (in_inst[5:4] != FUN_HALT);
      end
      I_LW: begin
        w_type      = T_I;
        w_is_load   = 1'b1;
        w_reg_write = 1'b1;
      end
      I_SW: begin
        w_type     = T_I;
        w_is_store = 1'b1;
      end
      I_SET: begin
        w_type      = T_I;
        w_reg_write = 1'b1;
      end
      B_BEQ: begin
        w_type      = T_B;
        w_is_branch = 1'b1;
      end
      M_MOV: begin
        w_type      = T_M;
        w_reg_write = 1'b1;
      end
      default: begin
        w_type = T_R;
      end
    endcase
    if (w_type == T_B) begin
      w_imm = {{4{in_inst[3]}}, in_inst[3:0]};
    end else begin
      w_imm = {4'h0, in_inst[3:0]};
    end
  end

  assign w_halted    = (r_state == ST_HALTED);
  // Gated by rst_n so nothing is offered while reset is held.
  assign in_ready    = rst_n && (!r_valid || out_ready) && !w_halted && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_valid     <= 1'b0;
      r_type      <= T_I;
      r_opcode    <= '0;
      r_funct     <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_imm       <= '0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_reg_write <= 1'b0;
      r_is_halt   <= 1'b0;
      r_count     <= '0;
    end else begin
      // A handshake counts even when flush drops the entry in the same cycle.
      if (w_handshake && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_accept) begin
        r_valid     <= 1'b1;
        r_type      <= w_type;
        r_opcode    <= in_inst[8:6];
        r_funct     <= in_inst[5:4];
        r_ra        <= in_inst[3:2];
        r_rb        <= in_inst[1:0];
        r_imm       <= w_imm;
        r_is_load   <= w_is_load;
        r_is_store  <= w_is_store;
        r_is_branch <= w_is_branch;
        r_reg_write <= w_reg_write;
        r_is_halt   <= w_is_halt;
        if (w_is_halt) begin
          r_state <= ST_HALTED;
        end
      end else if (w_handshake || flush) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_type      = r_type;
  assign out_opcode    = r_opcode;
  assign out_funct     = r_funct;
  assign out_ra        = r_ra;
  assign out_rb        = r_rb;
  assign out_imm       = r_imm;
  assign out_is_load   = r_is_load;
  assign out_is_store  = r_is_store;
  assign out_is_branch = r_is_branch;
  assign out_reg_write = r_reg_write;
  assign out_is_halt   = r_is_halt;
  assign halted        = w_halted;
  assign dec_count     = r_count;

endmodule

// File: tb/tb_inst_decode.sv
module tb_inst_decode;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [8:0]  in_inst;
  logic [1:0]  out_type, out_funct, out_ra, out_rb;
  logic [2:0]  out_opcode;
  logic [7:0]  out_imm;
  logic        out_is_load, out_is_store, out_is_branch, out_reg_write, out_is_halt, halted;
  logic [15:0] dec_count;

  logic        r2_rst_n, d2_in_valid, d2_in_ready, d2_flush, d2_out_valid, d2_out_ready;
  logic [8:0]  d2_in_inst;
  logic [1:0]  d2_type, d2_funct, d2_ra, d2_rb;
  logic [2:0]  d2_opcode;
  logic [7:0]  d2_imm;
  logic        d2_ld, d2_st, d2_br, d2_rw, d2_hl, d2_halted;
  logic [1:0]  d2_count;

  inst_decode #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_ra(out_ra), .out_rb(out_rb),
    .out_imm(out_imm), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_reg_write(out_reg_write), .out_is_halt(out_is_halt),
    .halted(halted), .dec_count(dec_count)
  );

  inst_decode #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(r2_rst_n), .in_valid(d2_in_valid), .in_inst(d2_in_inst), .in_ready(d2_in_ready),
    .flush(d2_flush), .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_type(d2_type),
    .out_opcode(d2_opcode), .out_funct(d2_funct), .out_ra(d2_ra), .out_rb(d2_rb),
    .out_imm(d2_imm), .out_is_load(d2_ld), .out_is_store(d2_st),
    .out_is_branch(d2_br), .out_reg_write(d2_rw), .out_is_halt(d2_hl),
    .halted(d2_halted), .dec_count(d2_count)
  );

  // Observed outputs: data fields only matter while out_valid is set.
  logic [23:0] obs_fields;
  logic [25:0] obs_raw, obs_m;
  assign obs_fields = {out_type, out_opcode, out_funct, out_ra, out_rb, out_imm,
                       out_is_load, out_is_store, out_is_branch, out_reg_write, out_is_halt};
  assign obs_raw = {out_valid, obs_fields, halted};
  assign obs_m   = {out_valid, (out_valid ? obs_fields : 24'h0), halted};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_valid;
  logic [23:0] m_fields;
  bit          m_halted;
  int          m_count;
  bit          rdy_obs, rdy_exp;

  // Decoded fields from the instruction tables, as plain arithmetic.
  function automatic logic [23:0] dec(input logic [8:0] inst);
    int op, fn, opd, ty, imm;
    bit ld, st, br, rw, hl;
    op  = int'(inst[8:6]);
    fn  = int'(inst[5:4]);
    opd = int'(inst[3:0]);
    if (op <= 2) ty = 3;
    else if (op <= 5) ty = 0;
    else if (op == 6) ty = 2;
    else ty = 1;
    imm = (ty == 2 && opd >= 8) ? (opd - 16 + 256) : opd;
    ld = (op == 3);
    st = (op == 4);
    br = (op == 6);
    hl = (op == 2 && fn == 3);
    rw = (op == 0) || (op == 1) || (op == 2 && fn != 3) || (op == 3) || (op == 5) || (op == 7);
    return {ty[1:0], op[2:0], fn[1:0], opd[3:2], opd[1:0], imm[7:0], ld, st, br, rw, hl};
  endfunction

  function automatic logic [25:0] exp_o();
    return {m_valid, (m_valid ? m_fields : 24'h0), m_halted};
  endfunction

  function automatic logic [8:0] rand_nohalt();
    logic [8:0] r;
    r = 9'($urandom);
    if (r[8:6] == 3'd2 && r[5:4] == 2'd3) r[5:4] = 2'd0;
    return r;
  endfunction

  task automatic model_reset();
    m_valid  = 0;
    m_fields = '0;
    m_halted = 0;
    m_count  = 0;
  endtask

  // Drives one cycle (called at posedge+1), advances the model, returns at next posedge+1.
  task automatic tick(input logic v, input logic [8:0] inst, input logic ordy, input logic fl);
    bit acc, hs;
    in_valid = v; in_inst = inst; out_ready = ordy; flush = fl;
    #1;
    rdy_exp = (!m_valid || ordy) && !m_halted && !fl;
    rdy_obs = in_ready;
    acc = v && rdy_exp;
    hs  = m_valid && ordy;
    if (hs && m_count < CMAX) m_count++;
    if (acc) begin
      m_fields = dec(inst);
      m_valid  = 1;
      if (m_fields[0]) m_halted = 1;
    end else if (hs || fl) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_inst = 9'h0C5; out_ready = 1'b1; flush = 1'b0;
    #1;
    n_checks++;
    if (obs_raw !== 26'h0) $display("FAIL reset_outputs: got %h expected %h", obs_raw, 26'h0);
    else n_pass++;
    n_checks++;
    if (dec_count !== 16'h0) $display("FAIL reset_count: got %0d expected 0", dec_count);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    // First accept in the first cycle after release.
    tick(1'b1, 9'b101_10_0110, 1'b0, 1'b0);
    n_checks++;
    if (rdy_obs !== 1'b1) $display("FAIL first_accept_ready: got %b expected 1", rdy_obs);
    else n_pass++;
    n_checks++;
    if (obs_m !== exp_o()) $display("FAIL first_accept_out: got %h expected %h", obs_m, exp_o());
    else n_pass++;
    tick(1'b0, 9'h0, 1'b1, 1'b0);
  endtask

  task automatic test_lw();
    int c0;
    c0 = m_count;
    tick(1'b1, 9'b011_00_0101, 1'b1, 1'b0);
    n_checks++;
    if ({out_valid, out_type, out_is_load, out_reg_write, out_imm} !== {1'b1, 2'd0, 1'b1, 1'b1, 8'h05})
      $display("FAIL lw_fields: got %b_%0d_%b_%b_%h expected 1_0_1_1_05",
               out_valid, out_type, out_is_load, out_reg_write, out_imm);
    else n_pass++;
    n_checks++;
    if (obs_m !== exp_o()) $display("FAIL lw_model: got %h expected %h", obs_m, exp_o());
    else n_pass++;
    tick(1'b0, 9'h0, 1'b1, 1'b0);
    n_checks++;
    if (dec_count !== 16'(c0 + 1)) $display("FAIL lw_count: got %0d expected %0d", dec_count, c0 + 1);
    else n_pass++;
  endtask

  task automatic test_bne();
    tick(1'b1, 9'b110_01_1110, 1'b1, 1'b0);
    n_checks++;
    if ({out_type, out_funct, out_is_branch, out_imm, out_reg_write} !== {2'd2, 2'd1, 1'b1, 8'hFE, 1'b0})
      $display("FAIL bne_fields: got %0d_%0d_%b_%h_%b expected 2_1_1_fe_0",
               out_type, out_funct, out_is_branch, out_imm, out_reg_write);
    else n_pass++;
    n_checks++;
    if (obs_m !== exp_o()) $display("FAIL bne_model: got %h expected %h", obs_m, exp_o());
    else n_pass++;
    tick(1'b0, 9'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [25:0] snap;
    c0 = m_count;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, rand_nohalt(), 1'b1, 1'b0);
      n_checks++;
      if (rdy_obs !== 1'b1 || obs_m !== exp_o())
        $display("FAIL b2b_out%0d: got rdy=%b %h expected rdy=1 %h", i, rdy_obs, obs_m, exp_o());
      else n_pass++;
    end
    snap = obs_m;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, rand_nohalt(), 1'b0, 1'b0);
      n_checks++;
      if (rdy_obs !== 1'b0 || obs_m !== snap)
        $display("FAIL b2b_stall%0d: got rdy=%b %h expected rdy=0 %h", i, rdy_obs, obs_m, snap);
      else n_pass++;
    end
    tick(1'b0, 9'h0, 1'b1, 1'b0);
    n_checks++;
    if (dec_count !== 16'(c0 + 4)) $display("FAIL b2b_count: got %0d expected %0d", dec_count, c0 + 4);
    else n_pass++;
  endtask

  task automatic test_flush();
    int c0;
    tick(1'b1, 9'b111_10_1001, 1'b0, 1'b0);
    c0 = m_count;
    tick(1'b1, 9'b000_01_0011, 1'b0, 1'b1);
    n_checks++;
    if (rdy_obs !== 1'b0 || out_valid !== 1'b0 || dec_count !== 16'(c0))
      $display("FAIL flush_hold: got rdy=%b valid=%b count=%0d expected rdy=0 valid=0 count=%0d",
               rdy_obs, out_valid, dec_count, c0);
    else n_pass++;
    // Flush together with a handshake: the handshake still counts.
    tick(1'b1, 9'b100_00_0001, 1'b0, 1'b0);
    tick(1'b1, 9'b001_00_0001, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || dec_count !== 16'(c0 + 1))
      $display("FAIL flush_handshake: got valid=%b count=%0d expected valid=0 count=%0d",
               out_valid, dec_count, c0 + 1);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_halted || $urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || dec_count !== 16'h0)
          $display("FAIL rand_reset%0d: got valid=%b halted=%b count=%0d expected 0 0 0",
                   i, out_valid, halted, dec_count);
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      tick(1'($urandom_range(0, 3) != 0), 9'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0));
      n_checks++;
      if (rdy_obs !== rdy_exp || obs_m !== exp_o() || dec_count !== 16'(m_count))
        $display("FAIL rand%0d: got rdy=%b %h cnt=%0d expected rdy=%b %h cnt=%0d",
                 i, rdy_obs, obs_m, dec_count, rdy_exp, exp_o(), m_count);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    tick(1'b1, 9'b010_11_0000, 1'b1, 1'b0);
    n_checks++;
    if (out_is_halt !== 1'b1 || halted !== 1'b1 || obs_m !== exp_o())
      $display("FAIL halt_out: got halt=%b halted=%b %h expected 1 1 %h",
               out_is_halt, halted, obs_m, exp_o());
    else n_pass++;
    tick(1'b1, 9'b011_00_0101, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 9'b011_00_0101, 1'b1, 1'b0);
      n_checks++;
      if (rdy_obs !== 1'b0 || halted !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL halt_block%0d: got rdy=%b halted=%b valid=%b expected 0 1 0",
                 i, rdy_obs, halted, out_valid);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (halted !== 1'b0) $display("FAIL halt_reset: got %b expected 0", halted);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    int exp_c;
    r2_rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      d2_in_valid = (k <= 5); d2_in_inst = 9'b000_00_0001; d2_out_ready = 1'b1; d2_flush = 1'b0;
      @(posedge clk); #1;
      exp_c = (k - 1 > 3) ? 3 : k - 1;
      n_checks++;
      if (d2_count !== 2'(exp_c) || d2_out_valid !== (k <= 5))
        $display("FAIL sat_count%0d: got count=%0d valid=%b expected count=%0d valid=%b",
                 k, d2_count, d2_out_valid, exp_c, (k <= 5));
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b1; r2_rst_n = 1'b1;
    in_valid = 1'b0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    d2_in_valid = 1'b0; d2_in_inst = '0; d2_out_ready = 1'b0; d2_flush = 1'b0;
    model_reset();
    #2;
    r2_rst_n = 1'b0;
    test_reset();
    test_lw();
    test_bne();
    test_back_to_back();
    test_flush();
    test_random();
    test_halt();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
